// File: rtl/bias_add_if.sv
// Valid/ready bundle between the gate accumulators, the bias-add scheduler and the activation units.
// The scheduler uses the slave modport; whoever feeds sums and drains results uses master.
interface bias_add_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [1:0]                    out_tag;
    logic                          out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/bias_add_scheduler.sv
// Round-robin scheduler sharing one registered bias adder among four LSTM gate sums.
// Each granted sum is added to its gate's bias and returned tagged over a valid/ready port.
module bias_add_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int BIAS_WIDTH = (DATA_WIDTH - 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bias_add_if.slave             bus,
    input  logic                  i_cfg_we,
    input  logic [1:0]            i_cfg_idx,
    input  logic [BIAS_WIDTH-1:0] i_cfg_bias,
    output logic [DATA_WIDTH-1:0] o_add_m1,
    output logic [BIAS_WIDTH-1:0] o_add_m2,
    input  logic [DATA_WIDTH-1:0] i_add_m4,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_ptr;
    logic [1:0]            r_tag;
    logic                  r_busy;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [1:0]            r_out_tag;
    logic [BIAS_WIDTH-1:0] r_bias [NUM_REQ];

    logic [DATA_WIDTH-1:0] w_gate_data [NUM_REQ];
    logic [1:0]            w_cand_idx  [NUM_REQ];
    logic [NUM_REQ-1:0]    w_cand_hit;
    logic [1:0]            w_grant_idx;
    logic                  w_any;
    logic                  w_issue;
    logic [NUM_REQ-1:0]    w_req_ready;

    // Candidate k is the gate k places after the pointer; scanning k upward gives round-robin order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_gate
            assign w_gate_data[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_cand_idx[gi]  = r_ptr + 2'(gi);
            assign w_cand_hit[gi]  = bus.req_valid[w_cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_grant_idx = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                w_grant_idx = w_cand_idx[k];
            end
        end
    end

    assign w_any   = |bus.req_valid;
    // Issue is suppressed while reset is held so the adder and grant lines stay quiet.
    assign w_issue = rst && (r_state == IDLE) && w_any;

    always_comb begin
        w_req_ready = '0;
        if (w_issue) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign o_add_m1      = w_issue ? w_gate_data[w_grant_idx] : '0;
    assign o_add_m2      = w_issue ? r_bias[w_grant_idx] : '0;

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign o_busy        = rst && r_busy;

    // Bias file is read combinationally at issue, so a same-edge write only affects later issues.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NUM_REQ; b++) begin
                r_bias[b] <= '0;
            end
        end else if (i_cfg_we) begin
            r_bias[i_cfg_idx] <= i_cfg_bias;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_tag       <= 2'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_tag   <= w_grant_idx;
                        r_ptr   <= w_grant_idx + 2'd1;
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_out_data  <= i_add_m4;
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_add_scheduler.sv
// Bench for bias_add_scheduler: table-driven single issues, directed corner sequences,
// and a randomized run scored against a transaction-level arbitration and bias model.
`timescale 1ns/1ps
module tb_bias_add_scheduler;
    localparam int DW = 16;
    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [BW-1:0] cfg_bias;
    logic [DW-1:0] add_m1;
    logic [BW-1:0] add_m2;
    logic [DW-1:0] add_m4;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bias_add_if #(.DATA_WIDTH(DW), .NUM_REQ(4)) bus ();

    bias_add_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .i_cfg_we  (cfg_we),
        .i_cfg_idx (cfg_idx),
        .i_cfg_bias(cfg_bias),
        .o_add_m1  (add_m1),
        .o_add_m2  (add_m2),
        .i_add_m4  (add_m4),
        .o_busy    (busy)
    );

    // External adder: one-cycle registered sum, bias zero-extended, wrapping.
    always @(posedge clk) add_m4 <= add_m1 + {9'b0, add_m2};

    typedef struct {
        int          gate;
        logic [6:0]  bias;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  t;
    } res_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic set_data(input int g, input logic [15:0] d);
        bus.req_data[g*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'h0;
        bus.out_ready = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic write_bias(input int idx, input logic [6:0] b);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_idx = 2'(idx);
        cfg_bias = b;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        bus.req_valid = 4'h0;
        bus.out_ready = 1'b1;
        #1;
        n = 0;
        while ((busy || bus.out_valid) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("drain timeout", 32'(busy), 32'(0));
    endtask

    task automatic run_single(input int g, input logic [15:0] d, input logic [6:0] b,
                              input logic [15:0] exp, input string nm);
        int n;
        @(negedge clk);
        bus.req_valid = 4'b1 << g;
        set_data(g, d);
        bus.out_ready = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready == 4'h0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, " grant"}, 32'(bus.req_ready), 32'(4'b1 << g));
        check({nm, " m1"}, 32'(add_m1), 32'(d));
        check({nm, " m2"}, 32'(add_m2), 32'(b));
        @(negedge clk);
        bus.req_valid = 4'h0;
        #1;
        check({nm, " wait valid"}, 32'(bus.out_valid), 32'(0));
        check({nm, " wait busy"}, 32'(busy), 32'(1));
        @(negedge clk);
        #1;
        check({nm, " valid"}, 32'(bus.out_valid), 32'(1));
        check({nm, " data"}, 32'(bus.out_data), 32'(exp));
        check({nm, " tag"}, 32'(bus.out_tag), 32'(g));
        $display("txn %s tag=%0d data=%h", nm, bus.out_tag, bus.out_data);
        @(negedge clk);
        #1;
        check({nm, " accepted"}, 32'(bus.out_valid), 32'(0));
        check({nm, " idle busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int gseq[$];
        int tseq[$];
        int rtags[$];
        res_t expq[$];
        logic [6:0]  mbias [4];
        logic [15:0] rdata [4];
        logic [3:0]  mask;
        int mptr;
        int pick;
        int nres;

        vecs[0] = '{1, 7'h07, 16'h1000, 16'h1007};
        vecs[1] = '{3, 7'h7F, 16'hFFFF, 16'h007E};
        vecs[2] = '{0, 7'h00, 16'h1234, 16'h1234};
        vecs[3] = '{2, 7'h40, 16'hFFC0, 16'h0000};
        vecs[4] = '{3, 7'h01, 16'h7FFF, 16'h8000};
        vecs[5] = '{0, 7'h55, 16'h8000, 16'h8055};

        rst = 1'b0;
        cfg_we = 1'b0;
        cfg_idx = 2'd0;
        cfg_bias = '0;
        bus.req_valid = 4'h0;
        bus.req_data = '0;
        bus.out_ready = 1'b0;

        // Reset with requests pending: nothing may be granted or driven to the adder.
        @(negedge clk);
        bus.req_valid = 4'hF;
        bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        @(negedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'(0));
        check("reset m1", 32'(add_m1), 32'(0));
        check("reset m2", 32'(add_m2), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset out_valid", 32'(bus.out_valid), 32'(0));
        check("reset out_data", 32'(bus.out_data), 32'(0));
        check("reset out_tag", 32'(bus.out_tag), 32'(0));
        do_reset();

        for (int i = 0; i < 6; i++) begin
            write_bias(vecs[i].gate, vecs[i].bias);
            run_single(vecs[i].gate, vecs[i].data, vecs[i].bias, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // All four gates valid, results drained immediately.
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'hF;
        for (int g = 0; g < 4; g++) set_data(g, 16'(16'h0100 * (g + 1)));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus.req_ready != 4'h0) begin
                gseq.push_back(oh2i(bus.req_ready));
                tseq.push_back(c);
            end
            if (bus.out_valid) begin
                rtags.push_back(int'(bus.out_tag));
                $display("txn rr tag=%0d data=%h", bus.out_tag, bus.out_data);
            end
            @(negedge clk);
        end
        check("rr grant count", 32'(gseq.size() >= 5), 32'(1));
        check("rr result count", 32'(rtags.size() >= 4), 32'(1));
        if (gseq.size() >= 5 && rtags.size() >= 4) begin
            for (int i = 0; i < 5; i++) check($sformatf("rr grant%0d", i), 32'(gseq[i]), 32'(i % 4));
            for (int i = 0; i < 4; i++) check($sformatf("rr spacing%0d", i), 32'(tseq[i+1] - tseq[i]), 32'(3));
            for (int i = 0; i < 4; i++) check($sformatf("rr tag%0d", i), 32'(rtags[i]), 32'(i));
        end
        drain();

        // Backpressure in HOLD while other gates keep requesting.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        set_data(0, 16'h2222);
        #1;
        check("hold grant", 32'(bus.req_ready), 32'(4'b0001));
        @(negedge clk);
        bus.req_valid = 4'b1110;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("hold valid", 32'(bus.out_valid), 32'(1));
            check("hold data", 32'(bus.out_data), 32'(16'h2222));
            check("hold tag", 32'(bus.out_tag), 32'(0));
            check("hold no grant", 32'(bus.req_ready), 32'(0));
            check("hold busy", 32'(busy), 32'(1));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        $display("txn hold tag=%0d data=%h", bus.out_tag, bus.out_data);
        @(negedge clk);
        #1;
        check("release valid", 32'(bus.out_valid), 32'(0));
        check("release busy", 32'(busy), 32'(0));
        check("release next grant", 32'(bus.req_ready), 32'(4'b0010));
        drain();

        // Bias write in the same cycle gate 2 issues: old bias used, new one afterwards.
        write_bias(2, 7'd5);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_data(2, 16'h0010);
        cfg_we = 1'b1;
        cfg_idx = 2'd2;
        cfg_bias = 7'd9;
        #1;
        check("wr-same grant", 32'(bus.req_ready), 32'(4'b0100));
        check("wr-same m2", 32'(add_m2), 32'(5));
        @(negedge clk);
        cfg_we = 1'b0;
        bus.req_valid = 4'h0;
        @(negedge clk);
        #1;
        check("wr-same valid", 32'(bus.out_valid), 32'(1));
        check("wr-same data", 32'(bus.out_data), 32'(16'h0015));
        check("wr-same tag", 32'(bus.out_tag), 32'(2));
        $display("txn wrsame tag=%0d data=%h", bus.out_tag, bus.out_data);
        drain();
        run_single(2, 16'h0010, 7'd9, 16'h0019, "newbias");

        // Reset while the result is in flight.
        write_bias(1, 7'h33);
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_data(1, 16'h0100);
        set_data(3, 16'h0300);
        #1;
        check("rstwait grant", 32'(bus.req_ready), 32'(4'b0010));
        @(negedge clk);
        bus.req_valid = 4'hF;
        rst = 1'b0;
        #1;
        check("rstwait busy", 32'(busy), 32'(0));
        check("rstwait ready", 32'(bus.req_ready), 32'(0));
        check("rstwait m1", 32'(add_m1), 32'(0));
        @(negedge clk);
        #1;
        check("rstwait out_valid", 32'(bus.out_valid), 32'(0));
        check("rstwait out_data", 32'(bus.out_data), 32'(0));
        check("rstwait ready2", 32'(bus.req_ready), 32'(0));
        check("rstwait m2", 32'(add_m2), 32'(0));
        @(negedge clk);
        bus.req_valid = 4'h0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("discarded absent", 32'(bus.out_valid), 32'(0));
        end
        @(negedge clk);
        bus.req_valid = 4'b1010;
        #1;
        check("post-rst ptr", 32'(bus.req_ready), 32'(4'b0010));
        check("post-rst bias", 32'(add_m2), 32'(0));
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        #1;
        check("post-rst data", 32'(bus.out_data), 32'(16'h0100));
        check("post-rst tag", 32'(bus.out_tag), 32'(1));
        drain();

        // Randomized traffic against the transaction-level model.
        do_reset();
        for (int g = 0; g < 4; g++) mbias[g] = '0;
        mptr = 0;
        nres = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            mask = 4'($urandom_range(0, 15));
            for (int g = 0; g < 4; g++) begin
                rdata[g] = 16'($urandom);
                set_data(g, rdata[g]);
            end
            bus.req_valid = mask;
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_bias = 7'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.req_ready != 4'h0) begin
                pick = -1;
                for (int k = 0; k < 4; k++)
                    if (pick < 0 && mask[(mptr + k) % 4]) pick = (mptr + k) % 4;
                check("rand grant", 32'(bus.req_ready), pick < 0 ? 32'(0) : 32'(1) << pick);
                if (pick >= 0) begin
                    expq.push_back('{rdata[pick] + {9'b0, mbias[pick]}, 2'(pick)});
                    mptr = (pick + 1) % 4;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("rand unexpected result", 32'(1), 32'(0));
                end else begin
                    res_t r;
                    r = expq.pop_front();
                    check("rand data", 32'(bus.out_data), 32'(r.d));
                    check("rand tag", 32'(bus.out_tag), 32'(r.t));
                    nres++;
                    $display("txn rand tag=%0d data=%h", bus.out_tag, bus.out_data);
                end
            end
            if (cfg_we) mbias[cfg_idx] = cfg_bias;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        bus.req_valid = 4'h0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("rand unexpected result", 32'(1), 32'(0));
                end else begin
                    res_t r;
                    r = expq.pop_front();
                    check("rand data", 32'(bus.out_data), 32'(r.d));
                    check("rand tag", 32'(bus.out_tag), 32'(r.t));
                    nres++;
                end
            end
            @(negedge clk);
        end
        check("rand queue empty", 32'(expq.size()), 32'(0));
        check("rand throughput", 32'(nres > 50), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
